// File: rtl/vsm.sv
// ---------------------------------------------------------------------------
// vsm: pipelined vector-scalar multiply-accumulate
//
// Each enabled cycle, every 8-bit lane of a is multiplied by the shared
// scalar b. The low 8 bits of each product are then added into that lane's
// 8-bit accumulator. All arithmetic is unsigned and wraps mod 256. Lanes
// never interact.
//
// Pipeline (rising clk):
//   stage 1 : capture a, b          vld_pipe[1] <= enable
//   stage 2 : register a_i*b mod 256  vld_pipe[2] <= vld_pipe[1]
//   stage 3 : acc_i += prod_i when vld_pipe[2]
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high; clears acc, valids and data regs
//   enable  a/b form a valid term on this edge
//   a       SIZE x 8-bit operand vector, lane 0 in the LSBs
//   b       8-bit unsigned scalar shared by all lanes
//   out     SIZE x 8-bit accumulator vector, driven straight from flops
// ---------------------------------------------------------------------------

// One lane: operand capture, truncated product, accumulator.
module vsm_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld1,     // stage-1 load (term entering)
    input  logic       vld1,    // stage-1 holds a valid term
    input  logic       vld2,    // stage-2 holds a valid product
    input  logic [7:0] a,
    input  logic [7:0] b_q,     // shared stage-1 scalar
    output logic [7:0] acc
);
    logic [7:0] a_q;
    logic [7:0] prod_q;

    // Stage 1: data regs only move when a term enters, which keeps
    // them quiet while enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    a_q <= '0;
        else if (ld1) a_q <= a;
    end

    // Stage 2: an 8x8 multiply in an 8-bit context keeps only the low
    // byte, which is exactly the mod-256 product we need.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     prod_q <= '0;
        else if (vld1) prod_q <= a_q * b_q;
    end

    // Stage 3: silent wrap, no saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     acc <= '0;
        else if (vld2) acc <= acc + prod_q;
    end
endmodule

module vsm #(
    parameter int SIZE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [8*SIZE-1:0] a,
    input  logic [7:0]        b,
    output logic [8*SIZE-1:0] out
);
    localparam int STAGES = 2;

    logic [STAGES:1]       vld_pipe;
    logic [7:0]            b_q;
    logic [SIZE-1:0][7:0]  a_v;
    logic [SIZE-1:0][7:0]  acc_v;

    assign a_v = a;
    assign out = acc_v;

    // Valid shift register; reset discards every in-flight term.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], enable};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       b_q <= '0;
        else if (enable) b_q <= b;
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        vsm_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .ld1   (enable),
            .vld1  (vld_pipe[1]),
            .vld2  (vld_pipe[2]),
            .a     (a_v[i]),
            .b_q   (b_q),
            .acc   (acc_v[i])
        );
    end
endmodule

// File: tb/tb_vsm.sv
module tb_vsm;
    localparam int SIZE = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [8*SIZE-1:0] a;
    logic [7:0]        b;
    logic [8*SIZE-1:0] out;

    int passed = 0;
    int total  = 0;
    logic [23:0] exp_q[$];

    vsm #(.SIZE(SIZE)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .a      (a),
        .b      (b),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Reference: lane-wise a_i*b added into acc, all mod 256.
    function automatic logic [23:0] mac(input logic [23:0] acc,
                                        input logic [23:0] av,
                                        input logic [7:0]  bv);
        logic [23:0] r;
        logic [15:0] p;
        for (int i = 0; i < SIZE; i++) begin
            p = {8'h00, av[8*i +: 8]} * {8'h00, bv};
            r[8*i +: 8] = acc[8*i +: 8] + p[7:0];
        end
        return r;
    endfunction

    // Drive one cycle, then compare out against the oldest expected value.
    task automatic run(input logic en, input logic [23:0] av,
                       input logic [7:0] bv, input string name);
        logic [23:0] e;
        enable = en; a = av; b = bv;
        @(posedge clk); #1;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, out=%06h", name, out);
        end else begin
            e = exp_q.pop_front();
            if (out !== e) $display("FAIL %s: out=%06h expected=%06h", name, out, e);
            else passed++;
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset = 1'b1; enable = 1'b0; a = '0; b = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; a = 24'hFFFFFF; b = 8'hFF;
        #1;
        total++;
        if (out !== 24'h0) $display("FAIL reset_async: out=%06h expected=000000", out);
        else passed++;
        // Enable is ignored while reset is held across edges.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (out !== 24'h0) $display("FAIL reset_hold: out=%06h expected=000000", out);
            else passed++;
        end
        reset = 1'b0; enable = 1'b0;
        exp_q.delete();
        exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        for (int i = 0; i < 3; i++) run(1'b0, 24'hFFFFFF, 8'hFF, "reset_release");
    endtask

    task automatic test_basic();
        do_reset();
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h010407);
        exp_q.push_back(24'h050E17);
        exp_q.push_back(24'h0E2032);
        exp_q.push_back(24'h0E2032);
        run(1'b1, 24'h010407, 8'h01, "basic");
        run(1'b1, 24'h020508, 8'h02, "basic");
        run(1'b1, 24'h030609, 8'h03, "basic");
        run(1'b1, 24'h000000, 8'h00, "basic");
        run(1'b0, 24'h000000, 8'h00, "basic");
        run(1'b0, 24'h000000, 8'h00, "basic");
    endtask

    task automatic test_latency();
        do_reset();
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        exp_q.push_back(24'h00000F); exp_q.push_back(24'h00000F);
        exp_q.push_back(24'h00000F);
        run(1'b1, 24'h000005, 8'h03, "latency");
        for (int i = 0; i < 4; i++) run(1'b0, 24'h0, 8'h0, "latency");
    endtask

    task automatic test_wrap();
        do_reset();
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        exp_q.push_back(24'h0000FE); exp_q.push_back(24'h0000FC);
        exp_q.push_back(24'h0000FC);
        run(1'b1, 24'h0000FF, 8'h02, "wrap");
        run(1'b1, 24'h0000FF, 8'h02, "wrap");
        for (int i = 0; i < 3; i++) run(1'b0, 24'h0, 8'h0, "wrap");
        // 0x10*0x10 = 0x100 truncates to 0: no change.
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h0000FC);
        run(1'b1, 24'h000010, 8'h10, "truncate");
        for (int i = 0; i < 3; i++) run(1'b0, 24'h0, 8'h0, "truncate");
    endtask

    // Continues from the FC left by test_wrap.
    task automatic test_gating();
        for (int i = 0; i < 5; i++) exp_q.push_back(24'h0000FC);
        for (int i = 0; i < 5; i++) run(1'b0, 24'hFFFFFF, 8'hFF, "gating");
        exp_q.push_back(24'h0000FC); exp_q.push_back(24'h0000FC);
        exp_q.push_back(24'h0000FD); exp_q.push_back(24'h0000FD);
        run(1'b1, 24'h000001, 8'h01, "gating_drain");
        for (int i = 0; i < 3; i++) run(1'b0, 24'hFFFFFF, 8'hFF, "gating_drain");
    endtask

    task automatic test_lanes();
        do_reset();
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        exp_q.push_back(24'h01FF00); exp_q.push_back(24'h01FF00);
        run(1'b1, 24'hFF0100, 8'hFF, "lanes");
        for (int i = 0; i < 3; i++) run(1'b0, 24'h0, 8'h0, "lanes");
    endtask

    task automatic test_mid_reset();
        do_reset();
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        exp_q.push_back(24'h010101);
        run(1'b1, 24'h010101, 8'h01, "midrst_pre");
        run(1'b0, 24'h0, 8'h0, "midrst_pre");
        run(1'b0, 24'h0, 8'h0, "midrst_pre");
        // Two terms in flight; neither has reached the accumulator yet.
        exp_q.push_back(24'h010101); exp_q.push_back(24'h010101);
        run(1'b1, 24'h020202, 8'h01, "midrst_inflight");
        run(1'b1, 24'h030303, 8'h01, "midrst_inflight");
        enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (out !== 24'h0) $display("FAIL midrst_async: out=%06h expected=000000", out);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h0);
        for (int i = 0; i < 4; i++) run(1'b0, 24'h0, 8'h0, "midrst_after");
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        logic        en_t[N+3];
        logic [23:0] a_t[N+3];
        logic [7:0]  b_t[N+3];
        logic [23:0] acc = '0;
        do_reset();
        for (int i = 0; i < N + 3; i++) begin
            en_t[i] = (i < N) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a_t[i]  = 24'($urandom);
            b_t[i]  = 8'($urandom);
        end
        // After edge i, out holds every enabled term j <= i-2.
        for (int i = 0; i < N + 3; i++) begin
            if (i >= 2 && en_t[i-2]) acc = mac(acc, a_t[i-2], b_t[i-2]);
            exp_q.push_back(acc);
        end
        for (int i = 0; i < N + 3; i++) run(en_t[i], a_t[i], b_t[i], "back_to_back");
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; a = '0; b = '0;
        #2;
        test_reset();
        test_basic();
        test_latency();
        test_wrap();
        test_gating();
        test_lanes();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vsm.md
Name: vsm

Overview:
- Pipelined vector-scalar multiply-accumulate unit for the neural network datapath.
- Each cycle with enable high, it multiplies every 8-bit lane of input vector a by the 8-bit scalar b, then adds each product into a per-lane 8-bit accumulator.
- The accumulator vector is presented on out. Typical use: accumulating weight-column × activation terms of a matrix-vector product, one scalar per cycle.

Parameters:
- SIZE, 3, number of 8-bit lanes in a and out.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  qualifies a/b as a valid term on the current rising edge.
- a  input  8*SIZE  operand vector; lane i = a[8i+7:8i], lane 0 in LSBs.
- b  input  8  unsigned scalar, shared by all lanes.
- out  output  8*SIZE  accumulator vector; lane i = out[8i+7:8i], same lane order as a.

Behaviour:
- Arithmetic is unsigned throughout.
  - Per-lane product = a_i * b, truncated to its low 8 bits (mod 256).
  - Accumulate: acc_i <= acc_i + product_i, mod 256. Wrap-around is silent; there is no saturation and no overflow flag.
  - Lanes are fully independent; there is no carry between lanes.
- Three-stage pipeline, all registers on the rising clk edge:
  - Stage 1 (edge N): capture a, b and valid1 <= enable.
  - Stage 2 (edge N+1): per-lane truncated products registered; valid2 <= valid1.
  - Stage 3 (edge N+2): if valid2, acc_i <= acc_i + prod_i; otherwise acc holds.
- out is driven directly from acc; there is no combinational path from a, b or enable to out.
- Latency: a term sampled at edge N is visible on out after edge N+2, i.e. from the cycle after.
- Throughput: one term per cycle. Back-to-back enabled terms each add exactly once, in order.
- Enable low:
  - No new term enters the pipeline.
  - Terms already in stages 1–2 still complete and are added (drain behaviour).
  - Stage-1 and stage-2 data registers may hold or load freely while their valid bit is 0.
- Reset (asynchronous, active-high):
  - Immediately clears acc (out = 0), all valid bits and all pipeline data registers to 0.
  - Mid-operation reset discards every in-flight term; none is added after reset deasserts.
  - While reset is high, enable is ignored.
  - First capture is at the first rising edge with reset low.
- There is no clear-accumulator input other than reset. A new accumulation requires asserting reset.
- Simultaneous events: enable high on the same edge a stage-3 add occurs is normal pipelined operation; both happen.

Test Plan:
- Basic accumulate, SIZE=3:
  - Stimulus: reset pulse, then enable=1 with a=010407/b=01, a=020508/b=02, a=030609/b=03 on consecutive edges, then a=0/b=0.
  - Response: one cycle after the third term out=010407, next cycle 050E17, next 0E2032.
- Latency check:
  - Stimulus: single enabled term a=000005/b=03 after reset, enable then low.
  - Response: out=000000 for two edges, then 00000F, then holds 00000F.
- Wrap and truncation:
  - Stimulus: a=0000FF, b=02 enabled twice.
  - Response: lane0 = FE, then FC; other lanes remain 00.
  - Stimulus: a=000010, b=10.
  - Response: lane0 adds 00, so out is unchanged.
- Enable gating:
  - Stimulus: enable=0 with a=FFFFFF/b=FF for 5 cycles.
  - Response: out unchanged. A term enabled just before enable falls is still added two edges later.
- Reset mid-operation:
  - Stimulus: two enabled terms in flight, then reset asserted between edges.
  - Response: out goes to 000000 immediately, without waiting for a clock edge, and stays 0 after reset release with enable=0.
- Lane independence:
  - Stimulus: a=FF0100, b=FF.
  - Response: out=01FF00; no carry from lane1 into lane2.
